// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: a one-entry holding register feeds a start/data/parity/stop
// frame FSM. Each bit is paced by an external bit timer's tick.
module uart_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic [7:0] data_in,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       timer_tick,
  output logic       timer_enable,
  output logic       timer_clear,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 par_en;
    logic                 par_odd;
  } hold_t;

  state_t               state_q, state_d;
  hold_t                hold_q;
  logic                 hold_valid, accept, load, tx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, par_en_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_idx_q;
  logic                 unused_data;

  // Bits above DATA_BITS are don't-care for narrow frames.
  assign unused_data = ^data_in;
  assign data_ready  = !hold_valid;
  assign accept      = data_valid && !hold_valid;
  assign load        = (state_d == START) && (state_q != START);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_q     <= '{data: data_in[DATA_BITS-1:0], par_en: parity_en, par_odd: parity_odd};
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_enable = 1'b1;
    timer_clear  = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    tx_d         = 1'b1;
    case (state_q)
      IDLE: begin
        timer_enable = 1'b0;
        timer_clear  = 1'b1;
        busy         = 1'b0;
        if (hold_valid) state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (timer_tick) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (timer_tick && bit_idx_q == IDX_W'(DATA_BITS - 1))
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_d = par_bit_q;
        if (timer_tick) state_d = STOP;
      end
      STOP: begin
        // Timer wraps on its own, so a queued byte starts with no idle gap.
        if (timer_tick && stop_idx_q == 1'(STOP_BITS - 1)) begin
          frame_done = 1'b1;
          state_d    = hold_valid ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q <= IDLE;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      tx      <= tx_d;
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else if (load) begin
      shift_q    <= hold_q.data;
      par_bit_q  <= hold_q.par_odd ? ~^hold_q.data : ^hold_q.data;
      par_en_q   <= hold_q.par_en;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else if (timer_tick) begin
      case (state_q)
        DATA: begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + IDX_W'(1);
        end
        STOP:    stop_idx_q <= stop_idx_q + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed + random bench for uart_tx_ctrl: an 8N1 instance checked cycle by cycle
// against a frame-level model, and a 5-data/2-stop instance checked directly.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  logic       clk = 1'b0;
  logic       async_nreset = 1'b0;
  logic [7:0] data_in = '0;
  logic       parity_en = 1'b0, parity_odd = 1'b0;
  logic       dv0 = 1'b0, dv1 = 1'b0, spur = 1'b0;
  logic       rdy0, en0, clr0, tx0, busy0, fd0, tick0;
  logic       rdy1, en1, clr1, tx1, busy1, fd1, tick1;
  logic [1:0] cnt0, cnt1;

  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1)) u0 (
    .clk(clk), .async_nreset(async_nreset), .data_in(data_in), .parity_en(parity_en),
    .parity_odd(parity_odd), .data_valid(dv0), .data_ready(rdy0), .timer_tick(tick0),
    .timer_enable(en0), .timer_clear(clr0), .tx(tx0), .busy(busy0), .frame_done(fd0));

  uart_tx_ctrl #(.DATA_BITS(5), .STOP_BITS(2)) u1 (
    .clk(clk), .async_nreset(async_nreset), .data_in(data_in), .parity_en(parity_en),
    .parity_odd(parity_odd), .data_valid(dv1), .data_ready(rdy1), .timer_tick(tick1),
    .timer_enable(en1), .timer_clear(clr1), .tx(tx1), .busy(busy1), .frame_done(fd1));

  // Bit timers, terminal count 3 -> 4 clk per bit. spur injects ticks while idle.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (clr0) cnt0 <= '0; else if (en0) cnt0 <= cnt0 + 2'd1;
      if (clr1) cnt1 <= '0; else if (en1) cnt1 <= cnt1 + 2'd1;
    end
  end
  assign tick0 = (cnt0 == 2'd3) || spur;
  assign tick1 = (cnt1 == 2'd3) || spur;

  typedef struct { logic [11:0] bits; int n; } frame_t;

  // Frame as a list of line bits: start, data LSB-first, optional parity, stops.
  function automatic frame_t mk_frame(input logic [7:0] d, input logic pe, input logic po,
                                      input int db, input int sb);
    frame_t f;
    int ones = 0;
    f.bits = '1;
    f.n = 0;
    f.bits[f.n] = 1'b0; f.n++;
    for (int i = 0; i < db; i++) begin
      f.bits[f.n] = d[i]; f.n++;
      ones += int'(d[i]);
    end
    if (pe) begin
      f.bits[f.n] = po ? (ones % 2 == 0) : (ones % 2 == 1); f.n++;
    end
    for (int i = 0; i < sb; i++) begin f.bits[f.n] = 1'b1; f.n++; end
    return f;
  endfunction

  frame_t acc_q[$];
  always @(posedge clk)
    if (async_nreset && dv0 && rdy0) acc_q.push_back(mk_frame(data_in, parity_en, parity_odd, 8, 1));

  // Line monitor for u0: every cycle of every frame compared against the model.
  int     rd_idx = 0, cyc = 0, end_cyc = -100, j = 0, n_frames = 0, mon_bad = 0;
  int     start_gap[$];
  bit     in_frame = 0;
  frame_t cur;
  always @(negedge clk) begin
    cyc++;
    if (!async_nreset) begin
      in_frame = 0;
      rd_idx   = acc_q.size();
    end else begin
      if (!in_frame && tx0 === 1'b0) begin
        if (rd_idx >= acc_q.size()) begin
          mon_bad++;
          $error("FAIL mon_start: observed start bit, required idle line (no byte pending)");
        end else begin
          cur = acc_q[rd_idx];
          rd_idx++;
          in_frame = 1;
          j = 0;
          start_gap.push_back(cyc - end_cyc - 1);
        end
      end
      if (in_frame) begin
        j++;
        assert (tx0 === cur.bits[(j-1)/4]) else begin
          mon_bad++;
          $error("FAIL mon_tx frame %0d clk %0d: observed %b required %b", n_frames, j, tx0, cur.bits[(j-1)/4]);
        end
        assert (fd0 === 1'(j == 4*cur.n - 1)) else begin
          mon_bad++;
          $error("FAIL mon_frame_done frame %0d clk %0d: observed %b required %b", n_frames, j, fd0, j == 4*cur.n - 1);
        end
        if (j < 4*cur.n) assert (busy0 === 1'b1) else begin
          mon_bad++;
          $error("FAIL mon_busy frame %0d clk %0d: observed %b required 1", n_frames, j, busy0);
        end
        if (j == 4*cur.n) begin
          in_frame = 0;
          n_frames++;
          end_cyc = cyc;
        end
      end else begin
        assert (tx0 === 1'b1 && fd0 === 1'b0) else begin
          mon_bad++;
          $error("FAIL mon_idle: observed tx=%b frame_done=%b required tx=1 frame_done=0", tx0, fd0);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; holds data_valid until the byte is taken.
  task automatic send0(input logic [7:0] d, input logic pe, input logic po);
    int n = 0;
    logic acc;
    data_in = d; parity_en = pe; parity_odd = po; dv0 = 1'b1;
    do begin
      acc = rdy0;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 2000);
    dv0 = 1'b0;
    chk("send0_accept", acc, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy0 || in_frame || rd_idx != acc_q.size()) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drained"}, 32'(n < 5000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, f0, s0, n, low, high, fd_cnt, fd_pos;
    logic acc;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx0, 1'b1);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_frame_done", fd0, 1'b0);
    chk("rst_timer_enable", en0, 1'b0);
    chk("rst_timer_clear", clr0, 1'b1);
    async_nreset = 1'b1;
    @(posedge clk); #1;

    // Ticks while idle must not start anything
    spur = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    spur = 1'b0;
    chk("idle_tick_busy0", busy0, 1'b0);
    chk("idle_tick_busy1", busy1, 1'b0);
    chk("idle_tick_tx0", tx0, 1'b1);

    // 8N1 0xA5: latency and 40-clk busy window
    send0(8'hA5, 1'b0, 1'b0);
    chk("a5_hold_busy", busy0, 1'b0);
    chk("a5_hold_ready", rdy0, 1'b0);
    @(posedge clk); #1;
    chk("a5_start_busy", busy0, 1'b1);
    chk("a5_start_tx_still_high", tx0, 1'b1);
    chk("a5_start_ready", rdy0, 1'b1);
    @(posedge clk); #1;
    chk("a5_tx_low", tx0, 1'b0);
    len = 2;
    while (len < 200) begin
      @(posedge clk); #1;
      if (!busy0) break;
      len++;
    end
    chk("a5_busy_len", len, 40);
    wait_idle("a5");
    chk("a5_frames", n_frames, 1);

    // Three bytes queued back-to-back; third waits while hold is full
    f0 = n_frames;
    s0 = start_gap.size();
    send0(8'h00, 1'b0, 1'b0);
    send0(8'hFF, 1'b0, 1'b0);
    chk("b2b_hold_full_ready", rdy0, 1'b0);
    send0(8'h3C, 1'b0, 1'b0);
    wait_idle("b2b");
    chk("b2b_frames", n_frames, f0 + 3);
    chk("b2b_started", start_gap.size(), s0 + 3);
    if (start_gap.size() == s0 + 3) begin
      chk("b2b_gap2", start_gap[s0+1], 0);
      chk("b2b_gap3", start_gap[s0+2], 0);
    end

    // Parity: 0x07 even then odd, 44-clk frames
    send0(8'h07, 1'b1, 1'b0);
    n = 0;
    while (!busy0 && n < 10) begin @(posedge clk); #1; n++; end
    len = 0;
    while (busy0 && len < 200) begin @(posedge clk); #1; len++; end
    chk("par_even_busy_len", len, 44);
    wait_idle("par_even");
    send0(8'h07, 1'b1, 1'b1);
    wait_idle("par_odd");
    chk("par_frames", n_frames, f0 + 5);

    // Reset in the middle of the data bits
    send0(8'h96, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    async_nreset = 1'b0;
    #1;
    chk("midrst_tx", tx0, 1'b1);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_ready", rdy0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    async_nreset = 1'b1;
    @(posedge clk); #1;
    f0 = n_frames;
    send0(8'h5A, 1'b0, 1'b0);
    wait_idle("post_rst");
    chk("post_rst_frames", n_frames, f0 + 1);

    // Random bytes, parity settings and gaps
    f0 = n_frames;
    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60);
      repeat (n) @(posedge clk);
      #1;
      send0(8'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle("rand");
    chk("rand_frames", n_frames, f0 + 20);

    // DATA_BITS=5, STOP_BITS=2, 0x1F: start, 5 ones, 2 stops = 32 clk
    data_in = 8'h1F; parity_en = 1'b0; dv1 = 1'b1;
    n = 0;
    do begin
      acc = rdy1;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    dv1 = 1'b0;
    chk("u1_accept", acc, 1'b1);
    n = 0;
    while (tx1 && n < 20) begin @(posedge clk); #1; n++; end
    low = 0; high = 0; fd_cnt = 0; fd_pos = 0;
    for (int k = 1; k <= 36; k++) begin
      if (k <= 4 && !tx1) low++;
      if (k >= 5 && k <= 32 && tx1) high++;
      if (fd1) begin fd_cnt++; fd_pos = k; end
      if (k == 32) chk("u1_busy_end", busy1, 1'b0);
      @(posedge clk); #1;
    end
    chk("u1_start_len", low, 4);
    chk("u1_ones_and_stops", high, 28);
    chk("u1_frame_done_count", fd_cnt, 1);
    chk("u1_frame_done_pos", fd_pos, 31);
    chk("u1_idle_tx", tx1, 1'b1);

    chk("monitor_clean", mon_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
